// File: rtl/sa_pkg.sv
// Shared types for the systolic-array weight feeder.
//   - Default array geometry (DATA_WIDTH, NUM_COLS).
//   - fsm_e: read-engine states.
//   - wt_desc_t: per-layer descriptor {base, len} sized for the default DEPTH / MAX_LEN.
package sa_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NUM_COLS   = 16;

  // Descriptor field widths for DEPTH=256 and MAX_LEN=25.
  localparam int unsigned DescBaseW = 8;
  localparam int unsigned DescLenW  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } fsm_e;

  typedef struct packed {
    logic [DescBaseW-1:0] base;
    logic [DescLenW-1:0]  len;
  } wt_desc_t;

endpackage

// File: rtl/wt_col_bank.sv
// One column weight bank: 1W1R synchronous SRAM, DEPTH x DATA_WIDTH.
//   clk, rst_n        clock, synchronous active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i      read port, data appears on rdata_o one cycle later
//   rdata_o           read data, held while re_i is low
// A same-cycle read and write of one address returns the old word.
module wt_col_bank #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wt_skew_feeder.sv
// Weight feeder for the systolic array: per-column weight banks plus a descriptor-driven read
// engine that streams len words per column, rep times, with column c lagging column 0 by c
// cycles.
//   clk, rst_n            clock, synchronous active-low reset
//   wr_*                  weight bank write port (any time)
//   cfg_*                 descriptor table write {base, len}
//   start_i/layer_i/rep_i run request; params latched on acceptance (rep 0 means 1)
//   stall_i               freeze the whole read pipeline
//   abort_i               drop the run immediately (beats stall and start)
//   weight_o/weight_vld_o per-column skewed weight stream
//   busy_o                engine active
//   done_o                one-cycle pulse the cycle after the last column's final word
module wt_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned MAX_LEN    = 25,
  parameter int unsigned MAX_REP    = 15,
  localparam int unsigned CW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned LENW = $clog2(MAX_LEN + 1),
  localparam int unsigned RW   = $clog2(MAX_REP + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en_i,
  input  logic [CW-1:0]                        wr_col_i,
  input  logic [AW-1:0]                        wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                wr_data_i,
  input  logic                                 cfg_we_i,
  input  logic [LW-1:0]                        cfg_layer_i,
  input  logic [AW-1:0]                        cfg_base_i,
  input  logic [LENW-1:0]                      cfg_len_i,
  input  logic                                 start_i,
  input  logic [LW-1:0]                        layer_i,
  input  logic [RW-1:0]                        rep_i,
  input  logic                                 stall_i,
  input  logic                                 abort_i,
  output logic [NUM_COLS-1:0][DATA_WIDTH-1:0]  weight_o,
  output logic [NUM_COLS-1:0]                  weight_vld_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  fsm_e                         state_q;
  wt_desc_t                     desc_q [NUM_LAYERS];
  logic [AW-1:0]                base_q;
  logic [LENW-1:0]              len_q;
  logic [RW-1:0]                rep_q;
  logic [LENW-1:0]              idx_q;
  logic [RW-1:0]                rcnt_q;
  logic [NUM_COLS-1:0][AW-1:0]  skew_addr_q;
  logic [NUM_COLS-1:0]          skew_vld_q;
  logic [NUM_COLS-1:0]          vld_q;
  logic                         done_q;

  logic                         issue_vld;
  logic [AW-1:0]                issue_addr;
  logic                         start_ok;

  assign issue_vld  = (state_q == StIssue);
  // Power-of-two DEPTH: the natural AW-bit wrap gives the mod-DEPTH address.
  assign issue_addr = base_q + AW'(idx_q);
  // A start coinciding with the done pulse is dropped; the run is still finishing.
  assign start_ok   = (state_q == StIdle) && !done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < NUM_LAYERS; i++) desc_q[i] <= '0;
      base_q      <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      rcnt_q      <= '0;
      skew_addr_q <= '0;
      skew_vld_q  <= '0;
      vld_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cfg_we_i) begin
        desc_q[cfg_layer_i] <= '{base: DescBaseW'(cfg_base_i), len: DescLenW'(cfg_len_i)};
      end
      if (abort_i) begin
        state_q    <= StIdle;
        skew_vld_q <= '0;
        vld_q      <= '0;
      end else begin
        if (!stall_i) begin
          skew_vld_q[0]  <= issue_vld;
          skew_addr_q[0] <= issue_addr;
          for (int c = 1; c < NUM_COLS; c++) begin
            skew_vld_q[c]  <= skew_vld_q[c-1];
            skew_addr_q[c] <= skew_addr_q[c-1];
          end
          // Valid follows the skew stage by the one-cycle bank read latency.
          vld_q <= skew_vld_q;
        end
        case (state_q)
          StIdle: begin
            if (start_ok && start_i) begin
              if (desc_q[layer_i].len == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= StIssue;
                base_q  <= AW'(desc_q[layer_i].base);
                len_q   <= LENW'(desc_q[layer_i].len);
                rep_q   <= (rep_i == '0) ? RW'(1) : rep_i;
                idx_q   <= '0;
                rcnt_q  <= '0;
              end
            end
          end
          StIssue: begin
            if (!stall_i) begin
              if (idx_q == len_q - 1'b1) begin
                idx_q <= '0;
                if (rcnt_q == rep_q - 1'b1) state_q <= StDrain;
                else                        rcnt_q  <= rcnt_q + 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          StDrain: begin
            // Skew chain empty means the last column's final word is already on the outputs.
            if (done_q)                              state_q <= StIdle;
            else if (!stall_i && skew_vld_q == '0)   done_q  <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_bank
    wt_col_bank #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_en_i && (wr_col_i == CW'(c))),
      .waddr_i (wr_addr_i),
      .wdata_i (wr_data_i),
      .re_i    (skew_vld_q[c] && !stall_i),
      .raddr_i (skew_addr_q[c]),
      .rdata_o (weight_o[c])
    );
  end

  assign weight_vld_o = vld_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;

endmodule

// File: tb/tb_wt_skew_feeder.sv
module tb_wt_skew_feeder;

  localparam int NC    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int NL    = 4;
  localparam int CW    = 4;
  localparam int AW    = 8;
  localparam int LW    = 2;
  localparam int LENW  = 5;
  localparam int RW    = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   wr_en_i;
  logic [CW-1:0]          wr_col_i;
  logic [AW-1:0]          wr_addr_i;
  logic [DW-1:0]          wr_data_i;
  logic                   cfg_we_i;
  logic [LW-1:0]          cfg_layer_i;
  logic [AW-1:0]          cfg_base_i;
  logic [LENW-1:0]        cfg_len_i;
  logic                   start_i;
  logic [LW-1:0]          layer_i;
  logic [RW-1:0]          rep_i;
  logic                   stall_i;
  logic                   abort_i;
  logic [NC-1:0][DW-1:0]  weight_o;
  logic [NC-1:0]          weight_vld_o;
  logic                   busy_o;
  logic                   done_o;

  wt_skew_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_i),
    .wr_col_i     (wr_col_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_layer_i  (cfg_layer_i),
    .cfg_base_i   (cfg_base_i),
    .cfg_len_i    (cfg_len_i),
    .start_i      (start_i),
    .layer_i      (layer_i),
    .rep_i        (rep_i),
    .stall_i      (stall_i),
    .abort_i      (abort_i),
    .weight_o     (weight_o),
    .weight_vld_o (weight_vld_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: memory image, descriptor table, current run shape.
  logic [DW-1:0] mem_m [NC][DEPTH];
  int            d_base [NL];
  int            d_len  [NL];
  int            m_base, m_len, m_n;

  // Column c presents word j (0..N-1) at timeline position 2+c+j after the start edge.
  function automatic logic [NC-1:0] exp_vld(input int p);
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = (p >= 2 + c) && (p <= 1 + c + m_n);
    return v;
  endfunction

  function automatic logic [NC-1:0][DW-1:0] exp_wt(input int p);
    logic [NC-1:0][DW-1:0] w;
    for (int c = 0; c < NC; c++) begin
      if ((p >= 2 + c) && (p <= 1 + c + m_n))
        w[c] = mem_m[c][(m_base + ((p - 2 - c) % m_len)) % DEPTH];
      else
        w[c] = '0;
    end
    return w;
  endfunction

  function automatic logic [NC-1:0][DW-1:0] vmask(input logic [NC-1:0] v);
    logic [NC-1:0][DW-1:0] m;
    for (int c = 0; c < NC; c++) m[c] = {DW{v[c]}};
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int layer, input int base, input int len);
    cfg_we_i = 1'b1; cfg_layer_i = LW'(layer); cfg_base_i = AW'(base); cfg_len_i = LENW'(len);
    tick();
    cfg_we_i = 1'b0;
    d_base[layer] = base;
    d_len[layer]  = len;
  endtask

  task automatic wr(input int c, input int a, input int d);
    wr_en_i = 1'b1; wr_col_i = CW'(c); wr_addr_i = AW'(a); wr_data_i = DW'(d);
    tick();
    wr_en_i = 1'b0;
    mem_m[c][a] = DW'(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++;
    if (weight_o !== '0) begin
      tests_failed++; $display("FAIL reset_weight got %h exp 0", weight_o);
    end
    tests_run++;
    if (weight_vld_o !== '0) begin
      tests_failed++; $display("FAIL reset_vld got %h exp 0", weight_vld_o);
    end
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctl got busy=%b done=%b exp 0 0", busy_o, done_o);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NL; i++) begin d_base[i] = 0; d_len[i] = 0; end
  endtask

  // Layer 3 is still at its reset descriptor (len 0).
  task automatic test_len0();
    start_i = 1'b1; layer_i = 2'd3; rep_i = 4'd5;
    tick();
    start_i = 1'b0;
    tests_run++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || weight_vld_o !== '0) begin
      tests_failed++;
      $display("FAIL len0_done got done=%b busy=%b vld=%h exp 1 0 0", done_o, busy_o,
               weight_vld_o);
    end
    // Start presented during the done pulse must be ignored.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL len0_start_at_done got done=%b busy=%b exp 0 0", done_o,
                               busy_o);
    end
    tick();
  endtask

  task automatic test_stream(input string name, input int layer, input int rep,
                             input int stall_mode, input bit wr_hit, input bit busy_start,
                             input int exp_done_tick);
    int pos, k, rep_e;
    bit st, done_seen, finished, do_wr;
    logic [NC-1:0] ev;
    logic [NC-1:0][DW-1:0] ew, mk;
    logic [DW-1:0] new_d;
    m_base = d_base[layer];
    m_len  = d_len[layer];
    rep_e  = (rep == 0) ? 1 : rep;
    m_n    = m_len * rep_e;
    start_i = 1'b1; layer_i = LW'(layer); rep_i = RW'(rep);
    tick();
    start_i = 1'b0;
    pos = 0; k = 0; done_seen = 0; finished = 0; do_wr = 0; new_d = '0;
    tests_run++;
    if (busy_o !== 1'b1 || weight_vld_o !== '0) begin
      tests_failed++; $display("FAIL %s start got busy=%b vld=%h exp 1 0", name, busy_o,
                               weight_vld_o);
    end
    while (!finished && k < 1000) begin
      k++;
      case (stall_mode)
        1:       st = (k >= 3 && k <= 5);
        2:       st = ($urandom_range(99) < 25);
        default: st = 1'b0;
      endcase
      stall_i = st;
      // Column 5's first read (address base) happens on the edge that reaches position 7.
      if (wr_hit && !st && pos + 1 == 7) begin
        new_d = ~mem_m[5][m_base];
        wr_en_i = 1'b1; wr_col_i = 4'd5; wr_addr_i = AW'(m_base); wr_data_i = new_d;
        do_wr = 1'b1;
      end
      if (busy_start && k == 4) begin
        start_i = 1'b1; layer_i = LW'((layer + 1) % NL); rep_i = 4'd2;
      end
      if (busy_start && k == 6) begin
        cfg_we_i = 1'b1; cfg_layer_i = 2'd0; cfg_base_i = 8'd100; cfg_len_i = 5'd3;
      end
      if (done_seen) start_i = busy_start;
      tick();
      start_i = 1'b0; wr_en_i = 1'b0; stall_i = 1'b0;
      if (cfg_we_i) begin cfg_we_i = 1'b0; d_base[0] = 100; d_len[0] = 3; end
      if (!st) pos++;
      if (done_seen) begin
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || weight_vld_o !== '0) begin
          tests_failed++;
          $display("FAIL %s post_done got busy=%b done=%b vld=%h exp 0 0 0", name, busy_o,
                   done_o, weight_vld_o);
        end
        finished = 1'b1;
      end else begin
        ev = exp_vld(pos);
        ew = exp_wt(pos);
        mk = vmask(ev);
        tests_run++;
        if (weight_vld_o !== ev) begin
          tests_failed++;
          $display("FAIL %s vld k=%0d got %h exp %h", name, k, weight_vld_o, ev);
        end
        tests_run++;
        if ((weight_o & mk) !== ew) begin
          tests_failed++;
          $display("FAIL %s data k=%0d got %h exp %h", name, k, weight_o & mk, ew);
        end
        tests_run++;
        if (done_o !== (!st && pos == m_n + NC + 1) || busy_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s ctl k=%0d got done=%b busy=%b exp %b 1", name, k, done_o, busy_o,
                   !st && pos == m_n + NC + 1);
        end
        if (!st && pos == m_n + NC + 1) begin
          done_seen = 1'b1;
          if (exp_done_tick >= 0) begin
            tests_run++;
            if (k != exp_done_tick) begin
              tests_failed++;
              $display("FAIL %s done_time got T+%0d exp T+%0d", name, k, exp_done_tick);
            end
          end
        end
      end
      if (do_wr) begin mem_m[5][m_base] = new_d; do_wr = 1'b0; end
    end
    if (!finished) begin
      tests_run++; tests_failed++;
      $display("FAIL %s timeout got no completion exp done by cycle budget", name);
    end
    if (busy_start) begin
      tick();
      tests_run++;
      if (busy_o !== 1'b0) begin
        tests_failed++; $display("FAIL %s start_at_done got busy=%b exp 0", name, busy_o);
      end
    end
  endtask

  task automatic test_abort();
    int seen_bad;
    m_base = d_base[0]; m_len = d_len[0]; m_n = m_len;
    start_i = 1'b1; layer_i = 2'd0; rep_i = 4'd1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    tests_run++;
    if (weight_vld_o !== exp_vld(6)) begin
      tests_failed++; $display("FAIL abort_pre got %h exp %h", weight_vld_o, exp_vld(6));
    end
    abort_i = 1'b1; stall_i = 1'b1; start_i = 1'b1;
    tick();
    abort_i = 1'b0; stall_i = 1'b0; start_i = 1'b0;
    tests_run++;
    if (weight_vld_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_now got vld=%h busy=%b done=%b exp 0 0 0", weight_vld_o, busy_o,
               done_o);
    end
    seen_bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0 || weight_vld_o !== '0) seen_bad++;
    end
    tests_run++;
    if (seen_bad != 0) begin
      tests_failed++; $display("FAIL abort_quiet got %0d active cycles exp 0", seen_bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_bad;
    start_i = 1'b1; layer_i = 2'd1; rep_i = 4'd3;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (weight_vld_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || weight_o !== '0) begin
      tests_failed++;
      $display("FAIL midrun_reset got vld=%h busy=%b done=%b wt=%h exp all 0", weight_vld_o,
               busy_o, done_o, weight_o);
    end
    seen_bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0 || weight_vld_o !== '0) seen_bad++;
    end
    tests_run++;
    if (seen_bad != 0) begin
      tests_failed++; $display("FAIL midrun_quiet got %0d active cycles exp 0", seen_bad);
    end
    for (int i = 0; i < NL; i++) begin d_base[i] = 0; d_len[i] = 0; end
  endtask

  initial begin
    rst_n = 1'b0; wr_en_i = 1'b0; wr_col_i = '0; wr_addr_i = '0; wr_data_i = '0;
    cfg_we_i = 1'b0; cfg_layer_i = '0; cfg_base_i = '0; cfg_len_i = '0;
    start_i = 1'b0; layer_i = '0; rep_i = '0; stall_i = 1'b0; abort_i = 1'b0;

    test_reset();
    test_len0();

    for (int c = 0; c < NC; c++)
      for (int a = 0; a < DEPTH; a++) wr(c, a, c * 16 + a);
    cfg(0, 0, 4);
    cfg(1, 254, 4);

    test_stream("basic", 0, 1, 0, 1'b0, 1'b0, 21);
    test_stream("wrap", 1, 3, 0, 1'b0, 1'b0, 29);
    test_stream("stall", 0, 1, 1, 1'b0, 1'b0, 24);
    test_abort();
    test_stream("after_abort", 0, 1, 0, 1'b0, 1'b0, 21);
    test_stream("wr_hit", 0, 2, 0, 1'b1, 1'b0, -1);
    test_stream("busy_start", 1, 1, 0, 1'b0, 1'b1, -1);
    test_stream("back_to_back", 0, 0, 0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 10; j++)
        wr($urandom_range(NC - 1), $urandom_range(DEPTH - 1), $urandom_range(255));
      cfg(2, $urandom_range(DEPTH - 1), $urandom_range(25, 1));
      test_stream("rand_stall", 2, $urandom_range(15), 2, 1'b0, 1'b0, -1);
    end

    test_reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
